// File: rtl/core_pkg.sv
// Shared core definitions: register file geometry, opcode space, instruction field positions.
// Imported by the issue scoreboard, its interface and the decoder.
package core_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NREG       = 32;

    // Instruction word field positions
    localparam int unsigned OP_MSB = 31;
    localparam int unsigned OP_LSB = 25;
    localparam int unsigned D_MSB  = 24;
    localparam int unsigned D_LSB  = 20;
    localparam int unsigned A_MSB  = 19;
    localparam int unsigned A_LSB  = 15;
    localparam int unsigned B_MSB  = 14;
    localparam int unsigned B_LSB  = 10;

    typedef logic [OP_MSB-OP_LSB:0] opcode_t;
    typedef logic [REG_ADDR_W-1:0]  reg_addr_t;

    localparam opcode_t OP_ALU  = 7'h00;
    localparam opcode_t OP_ALUI = 7'h01;
    localparam opcode_t OP_MUL  = 7'h02;
    localparam opcode_t OP_LD   = 7'h03;
    localparam opcode_t OP_ST   = 7'h04;
    localparam opcode_t OP_BR   = 7'h05;
    localparam opcode_t OP_JMP  = 7'h06;

    // Writeback bypass: a retiring write to x resolves a hazard on x this cycle (r0 never bypasses)
    function automatic logic wb_match(logic wb_valid, reg_addr_t wb_addr, reg_addr_t x);
        return wb_valid && (wb_addr == x) && (x != '0);
    endfunction

endpackage

// File: rtl/issue_scoreboard_if.sv
// Decode/writeback/issue signal bundle between decoder (master) and issue scoreboard (slave).
interface issue_scoreboard_if;
    import core_pkg::*;

    logic                 id_valid;
    opcode_t              id_op;
    reg_addr_t            id_addr_a;
    reg_addr_t            id_addr_b;
    reg_addr_t            id_addr_d;
    logic                 id_uses_a;
    logic                 id_uses_b;
    logic                 id_writes_d;
    logic                 wb_valid;
    reg_addr_t            wb_addr;
    logic                 flush;
    logic                 stall;
    logic                 issue;
    logic [NREG-1:0]      busy_vec;
    logic                 mul_busy;

    modport master (
        output id_valid, id_op, id_addr_a, id_addr_b, id_addr_d,
        output id_uses_a, id_uses_b, id_writes_d, wb_valid, wb_addr, flush,
        input  stall, issue, busy_vec, mul_busy
    );

    modport slave (
        input  id_valid, id_op, id_addr_a, id_addr_b, id_addr_d,
        input  id_uses_a, id_uses_b, id_writes_d, wb_valid, wb_addr, flush,
        output stall, issue, busy_vec, mul_busy
    );

endinterface

// File: rtl/mul_occupancy_ctr.sv
// Occupancy countdown for the non-pipelined multiplier: loads MUL_LAT-1 on issue,
// decrements to zero; mul_busy while nonzero. Not affected by flush.
module mul_occupancy_ctr #(
    parameter int unsigned MUL_LAT = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic mul_busy
);

    localparam int unsigned      CNT_W    = $clog2(MUL_LAT) + 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MUL_LAT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign mul_busy = (cnt_q != '0);

endmodule

// File: rtl/issue_scoreboard.sv
// Issue scoreboard: per-register pending-write tracking, RAW/WAW/multiplier hazard stall.
// Optional build macro ISSUE_PERF_CNT_EN adds the stall_cnt performance counter output.
module issue_scoreboard
    import core_pkg::*;
#(
    parameter int unsigned MUL_LAT = 5
) (
    input  logic              clk,
    input  logic              rst,
    issue_scoreboard_if.slave bus
`ifdef ISSUE_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    logic [NREG-1:0] busy_q, busy_d;
    logic            raw_a, raw_b, waw, mul_hz;
    logic            stall, issue, mul_busy;

    always_comb begin
        raw_a  = bus.id_uses_a & busy_q[bus.id_addr_a]
                 & ~wb_match(bus.wb_valid, bus.wb_addr, bus.id_addr_a);
        raw_b  = bus.id_uses_b & busy_q[bus.id_addr_b]
                 & ~wb_match(bus.wb_valid, bus.wb_addr, bus.id_addr_b);
        waw    = bus.id_writes_d & busy_q[bus.id_addr_d]
                 & ~wb_match(bus.wb_valid, bus.wb_addr, bus.id_addr_d);
        mul_hz = (bus.id_op == OP_MUL) & mul_busy;
        stall  = bus.id_valid & (raw_a | raw_b | waw | mul_hz) & ~bus.flush & ~rst;
        issue  = bus.id_valid & ~stall & ~bus.flush & ~rst;
    end

    // Writeback clears first so a same-cycle new producer of that register wins
    always_comb begin
        busy_d = busy_q;
        if (bus.flush) begin
            busy_d = '0;
        end else begin
            if (bus.wb_valid) begin
                busy_d[bus.wb_addr] = 1'b0;
            end
            if (issue && bus.id_writes_d && (bus.id_addr_d != '0)) begin
                busy_d[bus.id_addr_d] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    mul_occupancy_ctr #(
        .MUL_LAT (MUL_LAT)
    ) u_mul_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (issue && (bus.id_op == OP_MUL)),
        .mul_busy (mul_busy)
    );

`ifdef ISSUE_PERF_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (stall) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

    assign bus.stall    = stall;
    assign bus.issue    = issue;
    assign bus.busy_vec = busy_q;
    assign bus.mul_busy = mul_busy;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: per-cycle stimulus tables, expectations queued on drive.
module tb_issue_scoreboard;
    import core_pkg::*;

    typedef struct {
        logic      v;
        opcode_t   op;
        reg_addr_t a, b, d;
        logic      ua, ub, wd;
        logic      wbv;
        reg_addr_t wba;
        logic      fl, r;
        logic      es, ei;
        logic [31:0] eb;
        logic      emb;
    } cyc_t;

    typedef struct {
        logic        es, ei;
        logic [31:0] eb;
        logic        emb;
    } exp_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    issue_scoreboard_if bif ();

`ifdef ISSUE_PERF_CNT_EN
    logic [31:0] stall_cnt;
`endif

    issue_scoreboard #(
        .MUL_LAT (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bif)
`ifdef ISSUE_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic cyc_t mk(bit v, opcode_t op, int a, int b, int d, bit ua, bit ub, bit wd,
                                bit wbv, int wba, bit fl, bit r,
                                bit es, bit ei, logic [31:0] eb, bit emb);
        cyc_t c;
        c.v = v; c.op = op; c.a = 5'(a); c.b = 5'(b); c.d = 5'(d);
        c.ua = ua; c.ub = ub; c.wd = wd; c.wbv = wbv; c.wba = 5'(wba);
        c.fl = fl; c.r = r; c.es = es; c.ei = ei; c.eb = eb; c.emb = emb;
        return c;
    endfunction

    // Drive one cycle of stimulus and queue what the DUT must produce for it
    task automatic apply(input cyc_t c);
        exp_t e;
        bif.id_valid    = c.v;
        bif.id_op       = c.op;
        bif.id_addr_a   = c.a;
        bif.id_addr_b   = c.b;
        bif.id_addr_d   = c.d;
        bif.id_uses_a   = c.ua;
        bif.id_uses_b   = c.ub;
        bif.id_writes_d = c.wd;
        bif.wb_valid    = c.wbv;
        bif.wb_addr     = c.wba;
        bif.flush       = c.fl;
        rst             = c.r;
        e.es = c.es; e.ei = c.ei; e.eb = c.eb; e.emb = c.emb;
        exp_q.push_back(e);
    endtask

    task automatic test_reset_state();
        cyc_t tbl[$];
        exp_t e;
        tbl.push_back(mk(1, OP_ALU, 3, 4, 5, 1, 1, 1, 0, 0, 0, 1, 0, 0, 32'h0, 0));
        tbl.push_back(mk(0, OP_ALU, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0));
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({bif.stall, bif.issue} !== {e.es, e.ei}) begin
                errors++;
                $display("FAIL reset_state[%0d] stall/issue got %b%b want %b%b", i,
                         bif.stall, bif.issue, e.es, e.ei);
            end
            @(posedge clk); #1;
            checks++;
            if (bif.busy_vec !== e.eb || bif.mul_busy !== e.emb) begin
                errors++;
                $display("FAIL reset_state[%0d] busy/mul got %h/%b want %h/%b", i,
                         bif.busy_vec, bif.mul_busy, e.eb, e.emb);
            end
        end
`ifdef ISSUE_PERF_CNT_EN
        checks++;
        if (stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt);
        end
`endif
    endtask

    task automatic test_raw();
        cyc_t tbl[$];
        exp_t e;
        tbl.push_back(mk(1, OP_ALU, 0, 0, 3, 0, 0, 1, 0, 0, 0, 0, 0, 1, 32'h8, 0));
        tbl.push_back(mk(1, OP_ALU, 3, 0, 4, 1, 0, 1, 0, 0, 0, 0, 1, 0, 32'h8, 0));
        tbl.push_back(mk(1, OP_ALU, 3, 0, 4, 1, 0, 1, 1, 3, 0, 0, 0, 1, 32'h10, 0));
        tbl.push_back(mk(0, OP_ALU, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 32'h0, 0));
        tbl.push_back(mk(1, OP_ALU, 0, 0, 6, 0, 0, 1, 0, 0, 0, 0, 0, 1, 32'h40, 0));
        tbl.push_back(mk(1, OP_ST, 1, 6, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 32'h40, 0));
        tbl.push_back(mk(0, OP_ALU, 0, 0, 0, 0, 0, 0, 1, 6, 0, 0, 0, 0, 32'h0, 0));
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({bif.stall, bif.issue} !== {e.es, e.ei}) begin
                errors++;
                $display("FAIL raw[%0d] stall/issue got %b%b want %b%b", i,
                         bif.stall, bif.issue, e.es, e.ei);
            end
            @(posedge clk); #1;
            checks++;
            if (bif.busy_vec !== e.eb || bif.mul_busy !== e.emb) begin
                errors++;
                $display("FAIL raw[%0d] busy/mul got %h/%b want %h/%b", i,
                         bif.busy_vec, bif.mul_busy, e.eb, e.emb);
            end
        end
    endtask

    task automatic test_r0();
        cyc_t tbl[$];
        exp_t e;
        tbl.push_back(mk(1, OP_ALU, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 32'h0, 0));
        tbl.push_back(mk(1, OP_ALU, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 32'h0, 0));
        tbl.push_back(mk(1, OP_ALU, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 1, 32'h0, 0));
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({bif.stall, bif.issue} !== {e.es, e.ei}) begin
                errors++;
                $display("FAIL r0[%0d] stall/issue got %b%b want %b%b", i,
                         bif.stall, bif.issue, e.es, e.ei);
            end
            @(posedge clk); #1;
            checks++;
            if (bif.busy_vec !== e.eb || bif.mul_busy !== e.emb) begin
                errors++;
                $display("FAIL r0[%0d] busy/mul got %h/%b want %h/%b", i,
                         bif.busy_vec, bif.mul_busy, e.eb, e.emb);
            end
        end
    endtask

    task automatic test_waw();
        cyc_t tbl[$];
        exp_t e;
        tbl.push_back(mk(1, OP_ALU, 0, 0, 5, 0, 0, 1, 0, 0, 0, 0, 0, 1, 32'h20, 0));
        tbl.push_back(mk(1, OP_ALU, 0, 0, 5, 0, 0, 1, 0, 0, 0, 0, 1, 0, 32'h20, 0));
        tbl.push_back(mk(1, OP_ALU, 0, 0, 5, 0, 0, 1, 1, 5, 0, 0, 0, 1, 32'h20, 0));
        tbl.push_back(mk(0, OP_ALU, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 32'h0, 0));
        tbl.push_back(mk(0, OP_ALU, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0, 32'h0, 0));
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({bif.stall, bif.issue} !== {e.es, e.ei}) begin
                errors++;
                $display("FAIL waw[%0d] stall/issue got %b%b want %b%b", i,
                         bif.stall, bif.issue, e.es, e.ei);
            end
            @(posedge clk); #1;
            checks++;
            if (bif.busy_vec !== e.eb || bif.mul_busy !== e.emb) begin
                errors++;
                $display("FAIL waw[%0d] busy/mul got %h/%b want %h/%b", i,
                         bif.busy_vec, bif.mul_busy, e.eb, e.emb);
            end
        end
    endtask

    task automatic test_mul();
        cyc_t tbl[$];
        exp_t e;
`ifdef ISSUE_PERF_CNT_EN
        logic [31:0] start_cnt;
        start_cnt = stall_cnt;
`endif
        tbl.push_back(mk(1, OP_MUL, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 1));
        tbl.push_back(mk(1, OP_MUL, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0, 1));
        tbl.push_back(mk(1, OP_MUL, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0, 1));
        tbl.push_back(mk(1, OP_MUL, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0, 1));
        tbl.push_back(mk(1, OP_MUL, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0, 0));
        tbl.push_back(mk(1, OP_MUL, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 1));
        tbl.push_back(mk(1, OP_ALU, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 1));
        tbl.push_back(mk(0, OP_ALU, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1));
        tbl.push_back(mk(0, OP_ALU, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1));
        tbl.push_back(mk(0, OP_ALU, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0));
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({bif.stall, bif.issue} !== {e.es, e.ei}) begin
                errors++;
                $display("FAIL mul[%0d] stall/issue got %b%b want %b%b", i,
                         bif.stall, bif.issue, e.es, e.ei);
            end
            @(posedge clk); #1;
            checks++;
            if (bif.busy_vec !== e.eb || bif.mul_busy !== e.emb) begin
                errors++;
                $display("FAIL mul[%0d] busy/mul got %h/%b want %h/%b", i,
                         bif.busy_vec, bif.mul_busy, e.eb, e.emb);
            end
        end
`ifdef ISSUE_PERF_CNT_EN
        checks++;
        if (stall_cnt - start_cnt !== 32'd4) begin
            errors++;
            $display("FAIL mul_stall_cnt delta got %0d want 4", stall_cnt - start_cnt);
        end
`endif
    endtask

    task automatic test_flush();
        cyc_t tbl[$];
        exp_t e;
        tbl.push_back(mk(1, OP_MUL, 1, 1, 2, 0, 0, 1, 0, 0, 0, 0, 0, 1, 32'h4, 1));
        tbl.push_back(mk(1, OP_ALU, 1, 1, 7, 0, 0, 1, 0, 0, 0, 0, 0, 1, 32'h84, 1));
        tbl.push_back(mk(1, OP_ALU, 2, 7, 8, 1, 1, 1, 0, 0, 1, 0, 0, 0, 32'h0, 1));
        tbl.push_back(mk(1, OP_ALU, 2, 7, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 32'h0, 1));
        tbl.push_back(mk(0, OP_ALU, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0));
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({bif.stall, bif.issue} !== {e.es, e.ei}) begin
                errors++;
                $display("FAIL flush[%0d] stall/issue got %b%b want %b%b", i,
                         bif.stall, bif.issue, e.es, e.ei);
            end
            @(posedge clk); #1;
            checks++;
            if (bif.busy_vec !== e.eb || bif.mul_busy !== e.emb) begin
                errors++;
                $display("FAIL flush[%0d] busy/mul got %h/%b want %h/%b", i,
                         bif.busy_vec, bif.mul_busy, e.eb, e.emb);
            end
        end
    endtask

    task automatic test_reset_midop();
        cyc_t tbl[$];
        exp_t e;
        tbl.push_back(mk(1, OP_MUL, 1, 1, 9, 0, 0, 1, 0, 0, 0, 0, 0, 1, 32'h200, 1));
        tbl.push_back(mk(1, OP_ALU, 9, 9, 10, 1, 1, 1, 0, 0, 0, 1, 0, 0, 32'h0, 0));
        tbl.push_back(mk(0, OP_ALU, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0, 32'h0, 0));
        tbl.push_back(mk(1, OP_ALU, 9, 9, 9, 1, 1, 1, 0, 0, 0, 0, 0, 1, 32'h200, 0));
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({bif.stall, bif.issue} !== {e.es, e.ei}) begin
                errors++;
                $display("FAIL reset_midop[%0d] stall/issue got %b%b want %b%b", i,
                         bif.stall, bif.issue, e.es, e.ei);
            end
            @(posedge clk); #1;
            checks++;
            if (bif.busy_vec !== e.eb || bif.mul_busy !== e.emb) begin
                errors++;
                $display("FAIL reset_midop[%0d] busy/mul got %h/%b want %h/%b", i,
                         bif.busy_vec, bif.mul_busy, e.eb, e.emb);
            end
        end
`ifdef ISSUE_PERF_CNT_EN
        checks++;
        if (stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_midop_stall_cnt got %0d want 0", stall_cnt);
        end
`endif
    endtask

    initial begin
        rst             = 1'b1;
        bif.id_valid    = 1'b0;
        bif.id_op       = OP_ALU;
        bif.id_addr_a   = '0;
        bif.id_addr_b   = '0;
        bif.id_addr_d   = '0;
        bif.id_uses_a   = 1'b0;
        bif.id_uses_b   = 1'b0;
        bif.id_writes_d = 1'b0;
        bif.wb_valid    = 1'b0;
        bif.wb_addr     = '0;
        bif.flush       = 1'b0;
        @(posedge clk); #1;
        test_reset_state();
        test_raw();
        test_r0();
        test_waw();
        test_mul();
        test_flush();
        test_reset_midop();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expectations got %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
